// File: rtl/inst_decode_queue_if.sv
// Fetch-side and execute-side handshake bundle for the decode queue.
// slave = the queue itself, master = the surrounding pipeline (or bench).
interface inst_decode_queue_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_class;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [31:0]     out_imm;
  logic [PC_W-1:0] out_pc;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_class, out_funct3, out_funct7,
           out_rd, out_rs1, out_rs2, out_imm, out_pc
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_class, out_funct3, out_funct7,
           out_rd, out_rs1, out_rs2, out_imm, out_pc
  );
endinterface

// File: rtl/inst_decode_queue.sv
// RV32 decoder feeding a DEPTH-entry FIFO of decoded records; decode happens
// at push time so the execute side sees only registered state.
module inst_decode_queue #(
  parameter int       DEPTH       = 4,
  parameter int       PC_W        = 32,
  parameter bit       EN_CUST     = 1'b1,
  parameter bit [6:0] CUST_OPCODE = 7'h7F,
  parameter int       CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  inst_decode_queue_if.slave  bus,
  output logic [CNT_W-1:0]    illegal_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    C_ALU = 3'd0, C_JMP = 3'd1, C_MEM = 3'd2, C_CSR = 3'd3,
    C_SYS = 3'd4, C_CUST = 3'd5, C_ILL = 3'd7
  } cls_e;

  typedef struct packed {
    cls_e            cls;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic [PC_W-1:0] pc;
  } rec_t;

  rec_t dec, head;
  rec_t mem [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  logic [31:0] i;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  // ---------------------------------------------------------------- decode
  always_comb begin
    i     = bus.in_inst;
    op    = i[6:0];
    f3    = i[14:12];
    imm_i = {{20{i[31]}}, i[31:20]};
    imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    imm_u = {i[31:12], 12'b0};
    imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};

    dec     = '0;
    dec.cls = C_ILL;
    dec.f3  = f3;
    dec.f7  = i[31:25];
    dec.rd  = i[11:7];
    dec.rs1 = i[19:15];
    dec.rs2 = i[24:20];
    dec.pc  = bus.in_pc;

    if (op[1:0] == 2'b11) begin
      case (op)
        7'h37, 7'h17: begin dec.cls = C_ALU; dec.imm = imm_u; end
        7'h13:        begin dec.cls = C_ALU; dec.imm = imm_i; end
        7'h33:        dec.cls = C_ALU;
        7'h6F:        begin dec.cls = C_JMP; dec.imm = imm_j; end
        7'h67: if (f3 == 3'd0) begin dec.cls = C_JMP; dec.imm = imm_i; end
        7'h63: if (f3 != 3'd2 && f3 != 3'd3) begin
          dec.cls = C_JMP; dec.imm = imm_b;
        end
        7'h03: if (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) begin
          dec.cls = C_MEM; dec.imm = imm_i;
        end
        7'h23: if (f3 <= 3'd2) begin dec.cls = C_MEM; dec.imm = imm_s; end
        7'h73: begin
          if (f3 != 3'd0 && f3 != 3'd4) begin
            dec.cls = C_CSR; dec.imm = imm_i;
          end else if (i == 32'h0000_0073 || i == 32'h0010_0073 ||
                       i == 32'h3020_0073 || i == 32'h1050_0073) begin
            dec.cls = C_SYS;
          end
        end
        // Standard opcodes win if CUST_OPCODE is ever set to collide with one.
        default: if (EN_CUST && op == CUST_OPCODE) dec.cls = C_CUST;
      endcase
    end
  end

  // ------------------------------------------------------------------ fifo
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = bus.in_valid & ~full & ~flush;
  assign pop   = bus.out_ready & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      illegal_cnt <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
      if (push && dec.cls == C_ILL && illegal_cnt != '1)
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= dec;
  end

  assign head = empty ? '0 : mem[rd_ptr];

  assign bus.in_ready   = ~full;
  assign bus.out_valid  = ~empty;
  assign bus.out_class  = head.cls;
  assign bus.out_funct3 = head.f3;
  assign bus.out_funct7 = head.f7;
  assign bus.out_rd     = head.rd;
  assign bus.out_rs1    = head.rs1;
  assign bus.out_rs2    = head.rs2;
  assign bus.out_imm    = head.imm;
  assign bus.out_pc     = head.pc;
endmodule
